// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue between dispatch, CDB/RoB and memory.
// Entries snoop the CDB for operands. The head issues one memory transaction at a
// time. Loads issue once their operands are ready. Stores also wait until their
// RoB tag is the RoB head. A flush while a transaction is in flight drains that
// transaction without writing the RoB.
// Build option LSQ_IO_GUARD_EN: a load whose address is >= 32'h0003_0000 also
// waits for the RoB head, so no speculative I/O read is issued.
module load_store_queue #(
    parameter int LSQ_WIDTH = 3,
    parameter int RoB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 new_entry_en,
    input  logic [RoB_WIDTH-1:0] new_entry_RoBIndex,
    input  logic [6:0]           new_entry_opcode,
    input  logic [31:0]          new_entry_imm,
    input  logic [31:0]          new_entry_Vj,
    input  logic [31:0]          new_entry_Vk,
    input  logic [RoB_WIDTH:0]   new_entry_Qj,
    input  logic [RoB_WIDTH:0]   new_entry_Qk,
    input  logic                 RoB_update_en,
    input  logic [RoB_WIDTH-1:0] RoB_update_index,
    input  logic [31:0]          RoB_update_data,
    input  logic [RoB_WIDTH:0]   RoB_headIndex,
    input  logic                 flush_signal,
    input  logic                 mem_reply_en,
    input  logic [31:0]          mem_reply_data,
    output logic                 mem_query_en,
    output logic                 mem_query_type,
    output logic [31:0]          mem_query_addr,
    output logic [1:0]           mem_data_width,
    output logic [31:0]          mem_query_data,
    output logic                 RoB_write_en,
    output logic [RoB_WIDTH-1:0] RoB_write_index,
    output logic [31:0]          RoB_write_data,
    output logic                 isFull
);

    localparam int unsigned        LSQ_SIZE   = 1 << LSQ_WIDTH;
    localparam logic [RoB_WIDTH:0] NON_DEP    = {1'b1, {RoB_WIDTH{1'b0}}};
    localparam logic [LSQ_WIDTH:0] FULL_COUNT = {1'b1, {LSQ_WIDTH{1'b0}}};

    localparam logic [6:0] OP_LB  = 7'd11;
    localparam logic [6:0] OP_LH  = 7'd12;
    localparam logic [6:0] OP_LBU = 7'd14;
    localparam logic [6:0] OP_LHU = 7'd15;
    localparam logic [6:0] OP_SB  = 7'd16;
    localparam logic [6:0] OP_SH  = 7'd17;
    localparam logic [6:0] OP_SW  = 7'd18;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t state_q, state_d;

    // Entry storage
    logic                 busy        [LSQ_SIZE];
    logic                 is_store    [LSQ_SIZE];
    logic [1:0]           width       [LSQ_SIZE];
    logic                 is_unsigned [LSQ_SIZE];
    logic [31:0]          vj          [LSQ_SIZE];
    logic [31:0]          vk          [LSQ_SIZE];
    logic [RoB_WIDTH:0]   qj          [LSQ_SIZE];
    logic [RoB_WIDTH:0]   qk          [LSQ_SIZE];
    logic [31:0]          imm         [LSQ_SIZE];
    logic [RoB_WIDTH-1:0] rob_tag     [LSQ_SIZE];

    logic [LSQ_WIDTH-1:0] head, tail;
    logic [LSQ_WIDTH:0]   count;

    logic                 dec_store, dec_unsigned;
    logic [1:0]           dec_width;
    logic [31:0]          new_vj, new_vk;
    logic [RoB_WIDTH:0]   new_qj, new_qk;
    logic [RoB_WIDTH:0]   cdb_tag;
    logic                 dispatch, retire;
    logic                 head_ready, head_at_rob, io_block, can_issue;
    logic [31:0]          head_addr, store_data, load_result;

    logic                 q_en_d, q_type_d;
    logic [31:0]          q_addr_d, q_data_d;
    logic [1:0]           q_width_d;
    logic                 wr_en_d;
    logic [RoB_WIDTH-1:0] wr_idx_d;
    logic [31:0]          wr_data_d;

    assign isFull   = (count == FULL_COUNT);
    assign cdb_tag  = {1'b0, RoB_update_index};
    assign dispatch = new_entry_en && !isFull && !flush_signal;

    assign head_ready  = busy[head] && (qj[head] == NON_DEP) && (qk[head] == NON_DEP);
    assign head_addr   = vj[head] + imm[head];
    assign head_at_rob = (RoB_headIndex == {1'b0, rob_tag[head]});

`ifdef LSQ_IO_GUARD_EN
    assign io_block = !is_store[head] && (head_addr >= 32'h0003_0000) && !head_at_rob;
`else
    assign io_block = 1'b0;
`endif

    assign can_issue = head_ready && (is_store[head] ? head_at_rob : !io_block);

    // Decode the dispatched opcode; unknown opcodes behave as lw
    always_comb begin
        dec_store    = 1'b0;
        dec_width    = 2'd2;
        dec_unsigned = 1'b0;
        case (new_entry_opcode)
            OP_LB:  dec_width = 2'd0;
            OP_LH:  dec_width = 2'd1;
            OP_LBU: begin dec_width = 2'd0; dec_unsigned = 1'b1; end
            OP_LHU: begin dec_width = 2'd1; dec_unsigned = 1'b1; end
            OP_SB:  begin dec_width = 2'd0; dec_store = 1'b1; end
            OP_SH:  begin dec_width = 2'd1; dec_store = 1'b1; end
            OP_SW:  dec_store = 1'b1;
            default: ;
        endcase
    end

    // Resolve dispatched operands against the CDB in the same cycle
    always_comb begin
        new_vj = new_entry_Vj;
        new_qj = new_entry_Qj;
        new_vk = new_entry_Vk;
        new_qk = new_entry_Qk;
        if (RoB_update_en && (new_entry_Qj == cdb_tag)) begin
            new_vj = RoB_update_data;
            new_qj = NON_DEP;
        end
        if (RoB_update_en && (new_entry_Qk == cdb_tag)) begin
            new_vk = RoB_update_data;
            new_qk = NON_DEP;
        end
    end

    // Width-adjust head store data and the returning load data
    always_comb begin
        store_data  = vk[head];
        load_result = mem_reply_data;
        case (width[head])
            2'd0: begin
                store_data  = {24'h0, vk[head][7:0]};
                load_result = is_unsigned[head] ? {24'h0, mem_reply_data[7:0]}
                                                : {{24{mem_reply_data[7]}}, mem_reply_data[7:0]};
            end
            2'd1: begin
                store_data  = {16'h0, vk[head][15:0]};
                load_result = is_unsigned[head] ? {16'h0, mem_reply_data[15:0]}
                                                : {{16{mem_reply_data[15]}}, mem_reply_data[15:0]};
            end
            default: ;
        endcase
    end

    // Next state, next registered outputs and head retire
    always_comb begin
        state_d   = state_q;
        q_en_d    = mem_query_en;
        q_type_d  = mem_query_type;
        q_addr_d  = mem_query_addr;
        q_width_d = mem_data_width;
        q_data_d  = mem_query_data;
        wr_en_d   = 1'b0;
        wr_idx_d  = RoB_write_index;
        wr_data_d = RoB_write_data;
        retire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_signal && can_issue) begin
                    q_en_d    = 1'b1;
                    q_type_d  = is_store[head];
                    q_addr_d  = head_addr;
                    q_width_d = width[head];
                    q_data_d  = is_store[head] ? store_data : 32'h0;
                    state_d   = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_reply_en) begin
                    q_en_d  = 1'b0;
                    state_d = IDLE;
                    if (!flush_signal) begin
                        wr_en_d   = 1'b1;
                        wr_idx_d  = rob_tag[head];
                        wr_data_d = is_store[head] ? 32'h0 : load_result;
                        retire    = 1'b1;
                    end
                end else if (flush_signal) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_reply_en) begin
                    q_en_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and memory/RoB output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            mem_query_en    <= 1'b0;
            mem_query_type  <= 1'b0;
            mem_query_addr  <= '0;
            mem_data_width  <= '0;
            mem_query_data  <= '0;
            RoB_write_en    <= 1'b0;
            RoB_write_index <= '0;
            RoB_write_data  <= '0;
        end else if (rdy_in) begin
            state_q         <= state_d;
            mem_query_en    <= q_en_d;
            mem_query_type  <= q_type_d;
            mem_query_addr  <= q_addr_d;
            mem_data_width  <= q_width_d;
            mem_query_data  <= q_data_d;
            RoB_write_en    <= wr_en_d;
            RoB_write_index <= wr_idx_d;
            RoB_write_data  <= wr_data_d;
        end
    end

    // Queue storage: CDB snoop, dispatch at tail, retire at head, flush
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
                busy[i]        <= 1'b0;
                is_store[i]    <= 1'b0;
                width[i]       <= '0;
                is_unsigned[i] <= 1'b0;
                vj[i]          <= '0;
                vk[i]          <= '0;
                qj[i]          <= NON_DEP;
                qk[i]          <= NON_DEP;
                imm[i]         <= '0;
                rob_tag[i]     <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_signal) begin
                for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
                    busy[i] <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
                    if (busy[i] && RoB_update_en) begin
                        if (qj[i] == cdb_tag) begin
                            vj[i] <= RoB_update_data;
                            qj[i] <= NON_DEP;
                        end
                        if (qk[i] == cdb_tag) begin
                            vk[i] <= RoB_update_data;
                            qk[i] <= NON_DEP;
                        end
                    end
                end
                if (dispatch) begin
                    busy[tail]        <= 1'b1;
                    is_store[tail]    <= dec_store;
                    width[tail]       <= dec_width;
                    is_unsigned[tail] <= dec_unsigned;
                    vj[tail]          <= new_vj;
                    vk[tail]          <= new_vk;
                    qj[tail]          <= new_qj;
                    qk[tail]          <= new_qk;
                    imm[tail]         <= new_entry_imm;
                    rob_tag[tail]     <= new_entry_RoBIndex;
                    tail              <= tail + 1'b1;
                end
                if (retire) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                case ({dispatch, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
